// File: rtl/yolo_params_pkg.sv
// Shared YOLO datapath sizing and the convolution controller state type.
// Sizes here are the defaults picked up by conv_controller and conv_mac.
package yolo_params_pkg;

    localparam int IP_DATA_WIDTH = 8;
    localparam int IFMAP_SIZE    = 5;
    localparam int FILTER_SIZE   = 3;
    localparam int OFMAP_SIZE    = IFMAP_SIZE - FILTER_SIZE + 1;
    localparam int ACC_WIDTH     =
        2 * IP_DATA_WIDTH + $clog2(FILTER_SIZE * FILTER_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FILT,
        LOAD_IFMAP,
        COMPUTE,
        EMIT,
        DONE
    } conv_state_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int clog2_1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered unsigned multiply-accumulate.
// clr restarts the sum with the current product instead of adding to it.
module conv_mac #(
    parameter int DW = 8,
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] acc
);

    logic [2*DW-1:0] prod;

    assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

    // Accumulator: reset to zero, restart on clr, add product when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= (clr ? '0 : acc) + AW'(prod);
        end
    end

endmodule

// File: rtl/conv_controller.sv
// Stride-1, no-padding 2-D convolution sequencer around a single MAC.
// Loads filter then ifmap, computes each pixel serially, streams results.
module conv_controller #(
    parameter int IP_DATA_WIDTH = yolo_params_pkg::IP_DATA_WIDTH,
    parameter int IFMAP_SIZE    = yolo_params_pkg::IFMAP_SIZE,
    parameter int FILTER_SIZE   = yolo_params_pkg::FILTER_SIZE,
    parameter int OFMAP_SIZE    = IFMAP_SIZE - FILTER_SIZE + 1,
    parameter int ACC_WIDTH     =
        2 * IP_DATA_WIDTH + $clog2(FILTER_SIZE * FILTER_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IP_DATA_WIDTH-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          out_data,
    output logic [$clog2(OFMAP_SIZE)-1:0] out_row,
    output logic [$clog2(OFMAP_SIZE)-1:0] out_col,
    output logic                          out_last
);

    import yolo_params_pkg::*;

    localparam int FN = FILTER_SIZE * FILTER_SIZE;
    localparam int IN = IFMAP_SIZE * IFMAP_SIZE;
    localparam int KW = clog2_1(FILTER_SIZE);
    localparam int FA = clog2_1(FN);
    localparam int IA = clog2_1(IN);
    localparam int LW = clog2_1((IN > FN) ? IN : FN);
    localparam int CW = $clog2(OFMAP_SIZE);

    conv_state_t state_q;
    conv_state_t state_d;

    logic [IP_DATA_WIDTH-1:0] filt_buf  [FN];
    logic [IP_DATA_WIDTH-1:0] ifmap_buf [IN];

    logic [LW-1:0] load_cnt;
    logic [KW-1:0] ki;
    logic [KW-1:0] kj;
    logic [CW-1:0] row_q;
    logic [CW-1:0] col_q;

    logic          in_load;
    logic          in_fire;
    logic          load_last;
    logic          k_last;
    logic          pix_last;
    logic          out_fire;
    logic          mac_clr;
    logic          mac_en;
    logic [FA-1:0] filt_addr;
    logic [IA-1:0] ifmap_addr;

    assign in_load   = (state_q == LOAD_FILT) || (state_q == LOAD_IFMAP);
    assign in_fire   = in_load && in_valid;
    assign load_last = (state_q == LOAD_FILT)
                     ? (load_cnt == LW'(FN - 1))
                     : (load_cnt == LW'(IN - 1));
    assign k_last    = (ki == KW'(FILTER_SIZE - 1))
                    && (kj == KW'(FILTER_SIZE - 1));
    assign pix_last  = (row_q == CW'(OFMAP_SIZE - 1))
                    && (col_q == CW'(OFMAP_SIZE - 1));
    assign out_fire  = (state_q == EMIT) && out_ready;

    // Window addressing: filter (ki,kj) meets ifmap (row+ki, col+kj).
    assign filt_addr  = FA'(32'(ki) * FILTER_SIZE + 32'(kj));
    assign ifmap_addr = IA'((32'(row_q) + 32'(ki)) * IFMAP_SIZE
                          + 32'(col_q) + 32'(kj));

    assign mac_en  = (state_q == COMPUTE);
    assign mac_clr = mac_en && (ki == '0) && (kj == '0);

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign in_ready  = in_load;
    assign out_valid = (state_q == EMIT);
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = (state_q == EMIT) && pix_last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start) state_d = LOAD_FILT;
            LOAD_FILT:  if (in_fire && load_last) state_d = LOAD_IFMAP;
            LOAD_IFMAP: if (in_fire && load_last) state_d = COMPUTE;
            COMPUTE:    if (k_last) state_d = EMIT;
            EMIT: begin
                if (out_fire) state_d = pix_last ? DONE : COMPUTE;
            end
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Load index, kernel position and output coordinate counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt <= '0;
            ki       <= '0;
            kj       <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            if (in_fire) begin
                load_cnt <= load_last ? '0 : load_cnt + 1'b1;
            end
            if (state_q == COMPUTE) begin
                if (kj == KW'(FILTER_SIZE - 1)) begin
                    kj <= '0;
                    ki <= k_last ? '0 : ki + 1'b1;
                end else begin
                    kj <= kj + 1'b1;
                end
            end
            if ((state_q == IDLE) && start) begin
                row_q <= '0;
                col_q <= '0;
            end else if (out_fire && !pix_last) begin
                if (col_q == CW'(OFMAP_SIZE - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    // Buffer writes; contents are fully rewritten by every job.
    always_ff @(posedge clk) begin
        if (!rst && in_fire) begin
            if (state_q == LOAD_FILT) begin
                filt_buf[FA'(load_cnt)] <= in_data;
            end else begin
                ifmap_buf[IA'(load_cnt)] <= in_data;
            end
        end
    end

    conv_mac #(
        .DW (IP_DATA_WIDTH),
        .AW (ACC_WIDTH)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (ifmap_buf[ifmap_addr]),
        .b   (filt_buf[filt_addr]),
        .acc (out_data)
    );

endmodule

// File: tb/tb_conv_controller.sv
// Bench for conv_controller: table of directed jobs plus random jobs
// checked against a plain-arithmetic convolution and timing model.
module tb_conv_controller;

    localparam int FS = 3;
    localparam int IS = 5;
    localparam int OS = 3;
    localparam int NW = FS * FS + IS * IS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;

    conv_controller dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] filt [FS*FS];
    logic [7:0] ifm  [IS*IS];
    longint nominal_out [9] = '{126, 144, 162, 216, 234, 252, 306, 324, 342};
    bit chk_nominal;

    typedef struct {
        string  name;
        int     fmode;
        int     imode;
        int     stall;
        int     bp;
        bit     glitch;
        int     exp_load_end;
        int     exp_done;
        longint exp_first;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_data(input int fmode, input int imode);
        for (int i = 0; i < FS*FS; i++)
            filt[i] = (fmode == 0) ? 8'd2 :
                      (fmode == 1) ? 8'd255 : 8'($urandom_range(0, 255));
        for (int i = 0; i < IS*IS; i++)
            ifm[i] = (imode == 0) ? 8'(i + 1) :
                     (imode == 1) ? 8'd255 : 8'($urandom_range(0, 255));
    endtask

    function automatic longint ref_pix(input int r, input int c);
        longint s = 0;
        for (int i = 0; i < FS; i++)
            for (int j = 0; j < FS; j++)
                s += longint'(ifm[(r + i) * IS + c + j]) * longint'(filt[i * FS + j]);
        return s;
    endfunction

    // Called just after a clock edge; cycle 0 is the cycle start is high.
    // stall: 0 none, 1 alternate, 2 random. bp: >0 stall first emit, -1 random.
    task automatic run_job(input string nm, input int stall, input int bp,
                           input bit glitch, input int abort_at,
                           output int load_end, output int done_cyc,
                           output longint first_out);
        longint expv [9];
        int widx = 0;
        int pix = 0;
        int prev_evt = -1;
        bit pv = 0;
        longint pd = 0;
        int pr = 0;
        int pc = 0;
        int bp_left = (bp > 0) ? bp : 0;
        bit aborted = 0;
        load_end = -1;
        done_cyc = -1;
        first_out = -1;
        for (int p = 0; p < 9; p++) expv[p] = ref_pix(p / OS, p % OS);
        for (int t = 0; t < 3000; t++) begin
            start = (t == 0) || (glitch && (t == 20 || t == 40));
            rst = (abort_at > 0 && t == abort_at);
            case (stall)
                0: in_valid = 1'b1;
                1: in_valid = (t % 2 == 1);
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            in_data = (widx < FS*FS) ? filt[widx] :
                      (widx < NW) ? ifm[widx - FS*FS] : 8'd0;
            if (bp < 0) out_ready = ($urandom_range(0, 1) == 1);
            else if (out_valid && bp_left > 0) begin
                out_ready = 1'b0;
                bp_left--;
            end else out_ready = 1'b1;
            if (pv) begin
                chk({nm, " hold_valid"}, out_valid, 1);
                chk({nm, " hold_data"}, out_data, pd);
                chk({nm, " hold_row"}, out_row, pr);
                chk({nm, " hold_col"}, out_col, pc);
            end
            if (in_valid && in_ready) begin
                widx++;
                if (widx == NW) begin
                    load_end = t;
                    prev_evt = t;
                end
            end
            if (out_valid && !pv)
                chk({nm, " issue_gap"}, t - prev_evt, FS*FS + 1);
            if (out_valid && out_ready) begin
                chk({nm, " data"}, out_data, expv[pix]);
                if (chk_nominal) chk({nm, " nominal_val"}, out_data, nominal_out[pix]);
                chk({nm, " row"}, out_row, pix / OS);
                chk({nm, " col"}, out_col, pix % OS);
                chk({nm, " last"}, out_last, pix == 8);
                if (pix == 0) first_out = out_data;
                prev_evt = t;
                pix++;
                pv = 0;
            end else if (out_valid) begin
                pv = 1;
                pd = out_data;
                pr = out_row;
                pc = out_col;
            end else pv = 0;
            if (done) begin
                done_cyc = t;
                chk({nm, " done_gap"}, t - prev_evt, 1);
                chk({nm, " n_out"}, pix, 9);
            end
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                aborted = 1;
                chk({nm, " rst_busy"}, busy, 0);
                chk({nm, " rst_out_valid"}, out_valid, 0);
                chk({nm, " rst_in_ready"}, in_ready, 0);
                chk({nm, " rst_done"}, done, 0);
                break;
            end
            if (done_cyc >= 0) break;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (!aborted) begin
            if (done_cyc < 0) chk({nm, " timeout"}, 0, 1);
            chk({nm, " idle_busy"}, busy, 0);
            chk({nm, " idle_done"}, done, 0);
        end
    endtask

    initial begin
        int le;
        int dc;
        longint fo;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        chk_nominal = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_row", out_row, 0);
        chk("reset out_col", out_col, 0);
        chk("reset out_last", out_last, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        tbl[0] = '{"nominal",      0, 0, 0, 0, 0, 34,  125, 126};
        tbl[1] = '{"overflow",     1, 1, 0, 0, 0, 34,  125, 585225};
        tbl[2] = '{"backpressure", 0, 0, 0, 5, 0, 34,  130, 126};
        tbl[3] = '{"in_stall",     0, 0, 1, 0, 0, 67,  158, 126};
        tbl[4] = '{"start_glitch", 0, 0, 0, 0, 1, 34,  125, 126};

        for (int k = 0; k < 5; k++) begin
            set_data(tbl[k].fmode, tbl[k].imode);
            chk_nominal = (tbl[k].fmode == 0 && tbl[k].imode == 0);
            run_job(tbl[k].name, tbl[k].stall, tbl[k].bp, tbl[k].glitch, 0,
                    le, dc, fo);
            chk({tbl[k].name, " load_end"}, le, tbl[k].exp_load_end);
            chk({tbl[k].name, " done_cycle"}, dc, tbl[k].exp_done);
            chk({tbl[k].name, " first_out"}, fo, tbl[k].exp_first);
        end

        set_data(0, 0);
        chk_nominal = 1;
        run_job("abort", 0, 0, 0, 38, le, dc, fo);
        set_data(2, 2);
        chk_nominal = 0;
        run_job("abort2", 2, -1, 0, 20, le, dc, fo);
        set_data(0, 0);
        chk_nominal = 1;
        run_job("after_abort", 0, 0, 0, 0, le, dc, fo);
        chk("after_abort done_cycle", dc, 125);

        chk_nominal = 0;
        for (int r = 0; r < 6; r++) begin
            set_data(2, 2);
            run_job($sformatf("random%0d", r), 2, -1, 0, 0, le, dc, fo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_controller.md
# conv_controller

Sequential controller that sequences a single multiply-accumulate datapath through a full stride-1, no-padding 2-D convolution. It loads one filter and one ifmap over a valid/ready input stream into local buffers, computes each output pixel in FILTER_SIZE² MAC cycles, and streams results in row-major order over a valid/ready output port. It sits between the feature-map fetch logic and downstream result storage in the YOLO datapath.

## Interface
Parameters, all defaulting to the `yolo_params_pkg` values:
- IP_DATA_WIDTH, 8, width of ifmap and filter elements (unsigned).
- IFMAP_SIZE, 5, ifmap edge length.
- FILTER_SIZE, 3, filter edge length.
- OFMAP_SIZE, IFMAP_SIZE-FILTER_SIZE+1 (3), output edge length.
- ACC_WIDTH, 2*IP_DATA_WIDTH+$clog2(FILTER_SIZE*FILTER_SIZE) (20), accumulator and output width.

Ports:
- clk  in  1  single clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a job. Sampled in IDLE only.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output is accepted.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller accepts a word this cycle.
- in_data  in  IP_DATA_WIDTH  load word. The order is FILTER_SIZE² filter words row-major, then IFMAP_SIZE² ifmap words row-major.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_WIDTH  convolution sum for (out_row, out_col).
- out_row, out_col  out  $clog2(OFMAP_SIZE)  output coordinate.
- out_last  out  1  high with the final (OFMAP_SIZE-1, OFMAP_SIZE-1) result.

## Operation
- FSM states: IDLE, LOAD_FILT, LOAD_IFMAP, COMPUTE, EMIT, DONE.
- IDLE → LOAD_FILT when start=1. In any other state, start is ignored.
- LOAD_FILT: in_ready=1. Each handshake (in_valid&in_ready) writes the filter buffer at the next row-major index. After FILTER_SIZE² words → LOAD_IFMAP.
- LOAD_IFMAP: same, for IFMAP_SIZE² words. After the last word → COMPUTE with out_row=out_col=0.
- COMPUTE: the accumulator clears on entry. Each cycle it adds ifmap[out_row+i][out_col+j]*filter[i][j], with (i,j) advancing row-major. After FILTER_SIZE² cycles → EMIT.
- EMIT: out_valid=1, and out_data/out_row/out_col/out_last are held stable until out_ready=1. On acceptance:
  - if out_last → DONE;
  - otherwise advance out_col (wrapping to 0 and incrementing out_row at OFMAP_SIZE-1) → COMPUTE.
- DONE: done=1 for one cycle → IDLE.
- Arithmetic is unsigned; products are 2*IP_DATA_WIDTH bits. ACC_WIDTH cannot overflow for any input, so there is no saturation or truncation.
- in_valid is ignored outside the LOAD states. Buffer contents persist across jobs but are always fully rewritten before use.
- Reset (at any time, including mid-load or mid-compute) forces IDLE next cycle. It aborts the job, clears counters and the accumulator, and discards any partial load.

## Timing
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0.
- All outputs are registered or decoded from registered state. There is no combinational path from in_valid or out_ready to any output.
- With start at cycle 0, in_valid held high and out_ready held high (default sizes):
  - loads in cycles 1–34;
  - COMPUTE in cycles 35–43;
  - first out_valid at cycle 44;
  - each subsequent pixel follows 10 cycles later;
  - last EMIT at cycle 124;
  - done at cycle 125;
  - IDLE at cycle 126, where a new start is accepted.
- Per-pixel latency is FILTER_SIZE²+1 cycles minimum. Each cycle of out_ready=0 during EMIT adds one cycle. Gaps in in_valid stall the load one-for-one.

## Structure
- `yolo_params_pkg` holds:
  - IP_DATA_WIDTH, IFMAP_SIZE, FILTER_SIZE, OFMAP_SIZE, ACC_WIDTH;
  - the `conv_state_t` enum typedef.
- Sub-module `conv_mac`: registered multiply-accumulate with clear and enable inputs. The controller owns the FSM, counters, buffers and window-address generation.

## Test plan
- Nominal run: ifmap 1..25 row-major, filter all 2, out_ready=1. Required outputs are 126, 144, 162, 216, 234, 252, 306, 324, 342, with out_last only on 342, done at cycle 125, and timing as above.
- Overflow bound: all ifmap and filter words 255. All nine outputs must equal 585225.
- Output backpressure: nominal run with out_ready=0 for 5 cycles at the first EMIT. out_valid stays 1 and out_data stays 126 throughout, and done shifts to cycle 130.
- Input stalls: drop in_valid on alternate cycles. Loads complete by cycle 68 and the outputs are identical to the nominal run.
- Control robustness:
  - start pulsed during LOAD_IFMAP and during COMPUTE is ignored;
  - rst asserted during COMPUTE gives busy=0 and out_valid=0 the next cycle;
  - a following full nominal job produces correct results.
